// File: rtl/asyn_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter feeding the async FIFO write port from NUM_REQ producers.
// Define ASYN_FIFO_ARB_STATS_EN to add per-requester accepted-beat counters on grant_cnt.
module asyn_fifo_wr_arbiter #(
    parameter int DATA_BITS = 10,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                           w_clk,
    input  logic                           w_reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           write,
    output logic [DATA_BITS-1:0]           input_data,
    input  logic                           full,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
`ifdef ASYN_FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          grant_cnt
`endif
);
    localparam int GW = $clog2(NUM_REQ);

    // Handshake: a beat moves from requester i when req_valid[i] & req_ready[i] on a rising
    // w_clk edge; the FIFO takes a beat when write=1 (already qualified by ~full).
    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic [3:0]           beat_cnt;

    logic                 stage_free;
    logic                 accept;
    logic [DATA_BITS-1:0] sel_data;
    logic                 found;
    logic [GW-1:0]        next_id;
    logic [GW-1:0]        idx_b;

    assign write      = out_valid & ~full;
    assign input_data = out_data;
    assign stage_free = ~out_valid | write;
    assign busy       = (state == GRANT);

    always_comb begin
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                sel_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
            req_ready[i] = (state == GRANT) && (grant_id == GW'(i)) && stage_free;
        end
        accept = |(req_valid & req_ready);
    end

    // Search starts just after the last grant so every waiting requester is reached in turn.
    always_comb begin
        found   = 1'b0;
        next_id = grant_id;
        idx_b   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_b = GW'((int'(grant_id) + k) % NUM_REQ);
            if (!found && req_valid[idx_b]) begin
                found   = 1'b1;
                next_id = idx_b;
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_id  <= GW'(NUM_REQ - 1);
            beat_cnt  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
            end else if (write) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= next_id;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == 4'(MAX_BURST - 1)) begin
                            state <= IDLE;
                        end
                    end else if (!req_valid[grant_id]) begin
                        state <= IDLE;
                    end
                    // Otherwise back-pressure holds the burst in place.
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ASYN_FIFO_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (cnt[i] != 16'hFFFF)) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_asyn_fifo_wr_arbiter.sv
// Directed bench for asyn_fifo_wr_arbiter: burst split, round-robin, full stall, reset flush.
// Covers grant_cnt as well when ASYN_FIFO_ARB_STATS_EN is defined.
module tb_asyn_fifo_wr_arbiter;
    localparam int DW = 10;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              w_reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              write;
    logic [DW-1:0]     input_data;
    logic              full;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef ASYN_FIFO_ARB_STATS_EN
    logic [NR*16-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    asyn_fifo_wr_arbiter #(.DATA_BITS(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .w_clk      (clk),
        .w_reset    (w_reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .write      (write),
        .input_data (input_data),
        .full       (full),
        .grant_id   (grant_id),
`ifdef ASYN_FIFO_ARB_STATS_EN
        .grant_cnt  (grant_cnt),
`endif
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] src_mem [NR][32];
    int            src_len [NR];
    int            src_ptr [NR];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    logic          s_write;
    logic          s_busy;
    logic [NR-1:0] s_ready;
    logic [DW-1:0] s_data;
    int            wr_count;
    logic [63:0]   wr_hist;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        got_q.delete();
        exp_q.delete();
        wr_count = 0;
        wr_hist  = '0;
    endtask

    task automatic load(input int r, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            src_mem[r][src_len[r]] = base + DW'(k);
            src_len[r]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_ptr[i] < src_len[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_mem[i][src_ptr[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    // One clock: drive producers, sample just before the edge, retire accepted beats after it.
    task automatic cycle();
        logic [NR-1:0] acc;
        drive();
        #1;
        s_write = write;
        s_ready = req_ready;
        s_data  = input_data;
        s_busy  = busy;
        acc     = req_valid & req_ready;
        if (write) begin
            got_q.push_back(input_data);
            wr_count++;
        end
        wr_hist = {wr_hist[62:0], write};
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) src_ptr[i]++;
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check(tag, 32'(got_q[k]), 32'(exp_q[k]));
        end
    endtask

    task automatic do_reset();
        w_reset   = 1'b1;
        full      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        @(posedge clk);
        #1;
        w_reset = 1'b0;
        clear_src();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w_err;
        int r_err;
        int d_err;
        int b_err;

        w_reset   = 1'b1;
        full      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        clear_src();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_write", write, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 3);
        check("rst_busy", busy, 0);
        check("rst_input_data", input_data, 0);
        w_reset = 1'b0;

        // Requester 0 alone, 6 beats: burst of 4, one-cycle IDLE gap, then 2 more
        load(0, 6, 10'h001);
        for (int k = 1; k <= 6; k++) exp_q.push_back(DW'(k));
        repeat (10) cycle();
        check("burst_write_pattern", wr_hist[9:0], 10'b0011110110);
        check_stream("burst_data");
        check("burst_grant_id", grant_id, 0);
        check("burst_busy_end", busy, 0);

        // All four requesters valid: order 0,1,2,3,0,... with 4 beats each, 4/5 write duty
        do_reset();
        for (int r = 0; r < NR; r++) load(r, 8, DW'(r * 64));
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < 4; k++) exp_q.push_back(DW'(r * 64 + g * 4 + k));
        repeat (42) cycle();
        check("rr_write_count", wr_count, 32);
        check("rr_duty_window", wr_hist[39:30], 10'b1111011110);
        check_stream("rr_data");
        check("rr_last_grant", grant_id, 3);

        // full high for 10 cycles in the middle of requester 2's burst
        do_reset();
        load(2, 8, 10'h200);
        for (int k = 0; k < 8; k++) exp_q.push_back(10'h200 + DW'(k));
        w_err = 0; r_err = 0; d_err = 0; b_err = 0;
        for (int t = 0; t < 30; t++) begin
            full = (t >= 3 && t < 13);
            cycle();
            if (t >= 3 && t < 13) begin
                if (s_write !== 1'b0) w_err++;
                if (s_ready !== '0) r_err++;
                if (s_data !== 10'h201) d_err++;
                if (s_busy !== 1'b1) b_err++;
            end
        end
        full = 1'b0;
        check("full_no_write", w_err, 0);
        check("full_no_ready", r_err, 0);
        check("full_data_held", d_err, 0);
        check("full_busy_held", b_err, 0);
        check_stream("full_data");

        // Reset while a beat is buffered: write and req_ready drop without a clock edge
        do_reset();
        load(1, 4, 10'h111);
        repeat (2) cycle();
        drive();
        #1;
        check("pre_rst_write", write, 1);
        check("pre_rst_ready", req_ready, 4'b0010);
        w_reset = 1'b1;
        #1;
        check("async_rst_write", write, 0);
        check("async_rst_ready", req_ready, 0);
        check("async_rst_grant_id", grant_id, 3);
        #1;
        w_reset = 1'b0;
        clear_src();
        load(0, 2, 10'h0A0);
        load(1, 2, 10'h1A0);
        exp_q.push_back(10'h0A0);
        exp_q.push_back(10'h0A1);
        exp_q.push_back(10'h1A0);
        exp_q.push_back(10'h1A1);
        cycle();
        check("post_rst_first_grant", grant_id, 0);
        repeat (10) cycle();
        check_stream("post_rst_data");

`ifdef ASYN_FIFO_ARB_STATS_EN
        do_reset();
        check("stats_rst", grant_cnt, 0);
        load(1, 3, 10'h110);
        load(3, 5, 10'h330);
        repeat (20) cycle();
        check("stats_req0", grant_cnt[0 +: 16], 0);
        check("stats_req1", grant_cnt[16 +: 16], 3);
        check("stats_req2", grant_cnt[32 +: 16], 0);
        check("stats_req3", grant_cnt[48 +: 16], 5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
